// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - RV32I ALU-instruction decode/dispatch front end for a registered ALU
//
// Accepts one R-/I-type ALU instruction with its rs1/rs2 values. Legal encodings are
// decoded into a registered ALU opcode and operands. The one-cycle registered ALU
// result is captured and returned with rd. Illegal encodings skip the ALU and are
// returned at once with res_illegal set and res_data cleared.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           instruction handshake (in_ready high only in IDLE)
//   in_instr, in_rs1_val,
//   in_rs2_val                  instruction word and register operands
//   alu_a, alu_b, alu_op        registered drive to the external ALU
//   alu_out                     ALU result, valid one cycle after alu_* are driven
//   res_valid/res_ready         result handshake
//   res_data, res_rd,
//   res_illegal                 result value, destination register, illegal flag

module alu_dispatch #(
    parameter int DATA_W       = 32,
    parameter bit CHECK_FUNCT7 = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_rs1_val,
    input  logic [DATA_W-1:0] in_rs2_val,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [4:0]        res_rd,
    output logic              res_illegal
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_SLT  = 4'b1100;
    localparam logic [3:0] OP_SLTU = 4'b1101;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]        opc;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic              is_r, is_i;
    logic              f7_zero, f7_alt, alt;
    logic              is_shift_i;
    logic              dec_illegal;
    logic [3:0]        dec_op;
    logic [DATA_W-1:0] dec_b;

    // rs1 field is not needed: the rs1 value arrives already read
    logic unused_rs1_field;
    assign unused_rs1_field = ^in_instr[19:15];

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];

    always_comb begin
        is_r        = (opc == OPC_R);
        is_i        = (opc == OPC_I);
        f7_zero     = (f7 == 7'b0000000);
        f7_alt      = (f7 == F7_ALT);
        // With funct7 checking off, only bit 5 selects SUB/SRA
        alt         = CHECK_FUNCT7 ? f7_alt : f7[5];
        is_shift_i  = is_i && ((f3 == 3'b001) || (f3 == 3'b101));

        dec_op      = OP_ADD;
        dec_b       = '0;
        dec_illegal = 1'b0;

        if (is_r) begin
            dec_b = in_rs2_val;
        end else if (is_shift_i) begin
            dec_b = {{(DATA_W-5){1'b0}}, in_instr[24:20]};
        end else begin
            dec_b = {{(DATA_W-12){in_instr[31]}}, in_instr[31:20]};
        end

        case (f3)
            3'b000:  dec_op = (is_r && alt) ? OP_SUB : OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b010:  dec_op = OP_SLT;
            3'b011:  dec_op = OP_SLTU;
            3'b100:  dec_op = OP_XOR;
            3'b101:  dec_op = alt ? OP_SRA : OP_SRL;
            3'b110:  dec_op = OP_OR;
            default: dec_op = OP_AND;
        endcase

        if (!is_r && !is_i) begin
            dec_illegal = 1'b1;
        end else if (CHECK_FUNCT7) begin
            if (is_r && !f7_zero && !(f7_alt && ((f3 == 3'b000) || (f3 == 3'b101)))) begin
                dec_illegal = 1'b1;
            end
            if (is_i && (f3 == 3'b001) && !f7_zero) begin
                dec_illegal = 1'b1;
            end
            if (is_i && (f3 == 3'b101) && !f7_zero && !f7_alt) begin
                dec_illegal = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic accept;
    assign accept = (state == S_IDLE) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = dec_illegal ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_DONE;
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // ALU drive is held between ops because the ALU has no enable; only a
    // legal accept updates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= OP_ADD;
            res_data    <= '0;
            res_rd      <= '0;
            res_illegal <= 1'b0;
        end else begin
            if (accept) begin
                res_rd      <= in_instr[11:7];
                res_illegal <= dec_illegal;
                res_data    <= '0;
                if (!dec_illegal) begin
                    alu_a  <= in_rs1_val;
                    alu_b  <= dec_b;
                    alu_op <= dec_op;
                end
            end
            // ALU registered the ISSUE-cycle operands; its output is valid now
            if (state == S_WAIT) begin
                res_data <= alu_out;
            end
        end
    end

endmodule

// File: tb/tb_alu_dispatch.sv
// tb/tb_alu_dispatch.sv - self-checking bench for alu_dispatch

module tb_alu_dispatch;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic        res_illegal;

    alu_dispatch #(.DATA_W(32), .CHECK_FUNCT7(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_rs1_val (in_rs1_val),
        .in_rs2_val (in_rs2_val),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_rd     (res_rd),
        .res_illegal(res_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU environment model
    always @(posedge clk) begin
        case (alu_op)
            4'b0000: alu_out <= alu_a + alu_b;
            4'b0001: alu_out <= alu_a - alu_b;
            4'b0100: alu_out <= alu_a & alu_b;
            4'b0101: alu_out <= alu_a | alu_b;
            4'b0110: alu_out <= alu_a ^ alu_b;
            4'b1000: alu_out <= alu_a << alu_b[4:0];
            4'b1010: alu_out <= alu_a >> alu_b[4:0];
            4'b1011: alu_out <= $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'b1100: alu_out <= ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'b1101: alu_out <= (alu_a < alu_b) ? 32'd1 : 32'd0;
            default: alu_out <= 32'hDEADBEEF;
        endcase
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  op;
        logic [31:0] b;
        logic [31:0] data;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    localparam int NV = 16;
    vec_t vecs[NV];
    exp_t sbq[$];

    int checks   = 0;
    int failures = 0;

    logic [31:0] last_a, last_b;
    logic [3:0]  last_op;

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {imm, 5'd1, f3, rd, 7'b0010011};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    // Drive one instruction from IDLE; returns at the negedge where res_valid is seen.
    task automatic issue(input vec_t v);
        int n;
        chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
        in_instr   = v.instr;
        in_rs1_val = v.rs1;
        in_rs2_val = v.rs2;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sbq.push_back('{v.data, v.instr[11:7], v.ill});
        @(negedge clk);
        if (v.ill) begin
            chk("ill_res_valid_t1", {31'b0, res_valid}, 32'd1);
            chk("ill_alu_op_hold", {28'b0, alu_op}, {28'b0, last_op});
            chk("ill_alu_a_hold", alu_a, last_a);
            chk("ill_alu_b_hold", alu_b, last_b);
        end else begin
            chk("alu_op_t1", {28'b0, alu_op}, {28'b0, v.op});
            chk("alu_a_t1", alu_a, v.rs1);
            chk("alu_b_t1", alu_b, v.b);
            chk("res_valid_low_t1", {31'b0, res_valid}, 32'd0);
            last_op = v.op;
            last_a  = v.rs1;
            last_b  = v.b;
        end
        n = 1;
        while (!res_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, v.ill ? 32'd1 : 32'd3);
    endtask

    // Pop the scoreboard on a result handshake and confirm return to IDLE.
    task automatic collect();
        exp_t e;
        if (!res_valid) begin
            checks++;
            failures++;
            $display("FAIL collect_timeout actual=0 expected=1");
            return;
        end
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty actual=0 expected=1");
            return;
        end
        e = sbq.pop_front();
        chk("res_data", res_data, e.data);
        chk("res_rd", {27'b0, res_rd}, {27'b0, e.rd});
        chk("res_illegal", {31'b0, res_illegal}, {31'b0, e.ill});
        @(posedge clk);
        @(negedge clk);
        chk("res_valid_drop", {31'b0, res_valid}, 32'd0);
        chk("in_ready_back", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        chk({tag, "_res_valid"}, {31'b0, res_valid}, 32'd0);
        chk({tag, "_res_data"}, res_data, 32'd0);
        chk({tag, "_res_rd"}, {27'b0, res_rd}, 32'd0);
        chk({tag, "_res_illegal"}, {31'b0, res_illegal}, 32'd0);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_alu_b"}, alu_b, 32'd0);
        chk({tag, "_alu_op"}, {28'b0, alu_op}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{rtype(7'h00, 3'b000, 5'd1), 32'd5, 32'd7, 4'b0000, 32'd7, 32'd12, 1'b0};
        vecs[1]  = '{rtype(7'h20, 3'b000, 5'd2), 32'd3, 32'd5, 4'b0001, 32'd5, 32'hFFFFFFFE, 1'b0};
        vecs[2]  = '{itype({7'h20, 5'd4}, 3'b101, 5'd3), 32'h80000000, 32'h0000DEAD, 4'b1011,
                     32'd4, 32'hF8000000, 1'b0};
        vecs[3]  = '{itype(12'hFFF, 3'b000, 5'd4), 32'd1, 32'd9, 4'b0000, 32'hFFFFFFFF, 32'd0, 1'b0};
        vecs[4]  = '{itype(12'h001, 3'b011, 5'd5), 32'd0, 32'd0, 4'b1101, 32'd1, 32'd1, 1'b0};
        vecs[5]  = '{{20'h12345, 5'd6, 7'b0110111}, 32'd77, 32'd88, 4'b0000, 32'd0, 32'd0, 1'b1};
        vecs[6]  = '{rtype(7'h00, 3'b100, 5'd7), 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0110,
                     32'h0FF00FF0, 32'hFF00FF00, 1'b0};
        vecs[7]  = '{rtype(7'h00, 3'b010, 5'd8), 32'hFFFFFFFF, 32'd1, 4'b1100, 32'd1, 32'd1, 1'b0};
        vecs[8]  = '{rtype(7'h00, 3'b011, 5'd8), 32'hFFFFFFFF, 32'd1, 4'b1101, 32'd1, 32'd0, 1'b0};
        vecs[9]  = '{rtype(7'h00, 3'b101, 5'd9), 32'h80000000, 32'd31, 4'b1010, 32'd31, 32'd1, 1'b0};
        vecs[10] = '{rtype(7'h01, 3'b000, 5'd10), 32'd4, 32'd4, 4'b0000, 32'd0, 32'd0, 1'b1};
        vecs[11] = '{itype({7'h20, 5'd1}, 3'b001, 5'd11), 32'd4, 32'd4, 4'b0000, 32'd0, 32'd0, 1'b1};
        vecs[12] = '{itype(12'h800, 3'b110, 5'd12), 32'd1, 32'd0, 4'b0101, 32'hFFFFF800,
                     32'hFFFFF801, 1'b0};
        vecs[13] = '{itype(12'h0FF, 3'b111, 5'd13), 32'h12345678, 32'd0, 4'b0100, 32'h000000FF,
                     32'h00000078, 1'b0};
        vecs[14] = '{rtype(7'h00, 3'b001, 5'd14), 32'd1, 32'h25, 4'b1000, 32'h25, 32'h20, 1'b0};
        vecs[15] = '{rtype(7'h20, 3'b100, 5'd15), 32'd1, 32'd2, 4'b0000, 32'd0, 32'd0, 1'b1};

        last_a = '0; last_b = '0; last_op = '0;
        in_valid = 1'b0; in_instr = '0; in_rs1_val = '0; in_rs2_val = '0;
        res_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i]);
            collect();
        end

        // Consumer stall in DONE with stray in_valid activity
        res_ready = 1'b0;
        issue(vecs[0]);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            in_instr   = vecs[1].instr;
            in_rs1_val = 32'h55;
            in_valid   = 1'b1;
            @(negedge clk);
            chk("stall_res_valid", {31'b0, res_valid}, 32'd1);
            chk("stall_res_data", res_data, 32'd12);
            chk("stall_res_rd", {27'b0, res_rd}, 32'd1);
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        collect();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no_ghost_result", {31'b0, res_valid}, 32'd0);
        end

        // Reset asserted during WAIT aborts the op
        in_instr   = vecs[6].instr;
        in_rs1_val = vecs[6].rs1;
        in_rs2_val = vecs[6].rs2;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        last_a = '0; last_b = '0; last_op = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(vecs[1]);
        collect();
        issue(vecs[5]);
        collect();

        chk("sb_drained", sbq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
